// File: rtl/mem_responder_pkg.sv
// Shared encodings and helpers for the mem_responder memory model.
// Imported by the responder top and by anything that drives its dmem port.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_W_BYTE = 2'd0,
        DMEM_W_HALF = 2'd1,
        DMEM_W_WORD = 2'd2,
        DMEM_W_RSVD = 2'd3
    } dmem_width_e;

    localparam logic DMEM_CMD_RD = 1'b0;
    localparam logic DMEM_CMD_WR = 1'b1;

    // Alignment/encoding fault for a dmem access, given the low two offset bits.
    function automatic logic dmem_bad_access(logic [1:0] width, logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        case (width)
            DMEM_W_BYTE: bad = 1'b0;
            DMEM_W_HALF: bad = lo[0];
            DMEM_W_WORD: bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// imem/dmem request-response bus between the core (master) and its memory (slave).
// Handshake: *_req is accepted at every clk edge where it is high (no ready, no backpressure);
// *_resp is high for exactly one cycle per accepted request, in order, and qualifies *_rdata/*_err.
interface mem_responder_if #(
    parameter int XLEN    = 32,
    parameter int BUS_WID = 64
);
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [BUS_WID-1:0] imem_rdata;
    logic               imem_resp;
    logic               imem_err;

    logic               dmem_req;
    logic               dmem_cmd;
    logic [1:0]         dmem_width;
    logic [XLEN-1:0]    dmem_addr;
    logic [XLEN-1:0]    dmem_wdata;
    logic [XLEN-1:0]    dmem_rdata;
    logic               dmem_resp;
    logic               dmem_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_resp, imem_err,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_resp, imem_err,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err
    );

endinterface

// File: rtl/mem_responder_resp_pipe.sv
// LAT-deep response delay line of {vld, payload}; cleared by asynchronous reset.
// A stage's payload only advances when the stage before it is valid, so the last stage holds
// the most recent response between valid cycles.
module resp_pipe #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] vld;
    logic [W-1:0]   data [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                data[i] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            if (in_vld) begin
                data[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign out_vld  = vld[LAT-1];
    assign out_data = data[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Word-array memory answering the core's imem (line fetch) and dmem (byte/half/word) buses
// in order after a fixed latency, with range, alignment and encoding errors flagged on *_err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BUS_WID   = 64,
    parameter int              MEM_AW    = 14,
    parameter logic [XLEN-1:0] BASE      = '0,
    parameter int              IMEM_LAT  = 1,
    parameter int              DMEM_LAT  = 1,
    parameter string           INIT_FILE = ""
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int NW    = BUS_WID / XLEN;
    localparam int NB    = XLEN / 8;
    localparam int DB    = $clog2(NB);
    localparam int WORDS = 1 << MEM_AW;

    logic [XLEN-1:0] mem [WORDS];

    // dmem decode: offset from BASE, error, lane enables and replicated write data
    logic [XLEN-1:0]   d_off;
    logic [MEM_AW-1:0] d_idx;
    logic              d_err;
    logic              d_we;
    logic [NB-1:0]     d_be;
    logic [XLEN-1:0]   d_wd;
    logic [XLEN-1:0]   d_rd;
    logic [XLEN:0]     d_pay;

    always_comb begin
        d_off = bus.dmem_addr - BASE;
        d_idx = d_off[MEM_AW+1:2];
        d_err = (d_off[XLEN-1:MEM_AW+2] != '0) || dmem_bad_access(bus.dmem_width, d_off[1:0]);
        d_we  = bus.dmem_req && (bus.dmem_cmd == DMEM_CMD_WR) && !d_err;
        d_be  = '0;
        d_wd  = bus.dmem_wdata;
        case (bus.dmem_width)
            DMEM_W_BYTE: begin
                d_be = NB'(1) << d_off[DB-1:0];
                d_wd = {NB{bus.dmem_wdata[7:0]}};
            end
            DMEM_W_HALF: begin
                d_be = NB'(3) << {d_off[DB-1:1], 1'b0};
                d_wd = {(NB/2){bus.dmem_wdata[15:0]}};
            end
            default: d_be = '1;
        endcase
        // Reads see the array as it stands before this edge's write.
        d_rd  = d_err ? '0 : mem[d_idx];
        d_pay = {d_err, d_rd};
    end

    always_ff @(posedge clk) begin
        if (d_we) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wd[8*b +: 8];
                end
            end
        end
    end

    // imem decode: BASE is aligned to the memory size, so the line base is in range iff the
    // raw offset is, and a line never straddles the end of the array.
    logic [XLEN-1:0]    i_off;
    logic               i_err;
    logic [MEM_AW-1:0]  i_base;
    logic [BUS_WID-1:0] i_line;
    logic [BUS_WID-1:0] i_rd;
    logic [BUS_WID:0]   i_pay;
    logic               unused_imem_lo;

    always_comb begin
        i_off  = bus.imem_addr - BASE;
        i_err  = (i_off[XLEN-1:MEM_AW+2] != '0);
        i_base = i_off[MEM_AW+1:2] & ~MEM_AW'(NW - 1);
        i_line = '0;
        for (int k = 0; k < NW; k++) begin
            i_line[k*XLEN +: XLEN] = mem[i_base | MEM_AW'(k)];
        end
        i_rd  = i_err ? '0 : i_line;
        i_pay = {i_err, i_rd};
    end

    assign unused_imem_lo = ^i_off[1:0];

    logic               d_vld;
    logic [XLEN:0]      d_out;
    logic               i_vld;
    logic [BUS_WID:0]   i_out;

    resp_pipe #(.W(XLEN + 1), .LAT(DMEM_LAT)) u_dmem_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bus.dmem_req),
        .in_data  (d_pay),
        .out_vld  (d_vld),
        .out_data (d_out)
    );

    resp_pipe #(.W(BUS_WID + 1), .LAT(IMEM_LAT)) u_imem_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bus.imem_req),
        .in_data  (i_pay),
        .out_vld  (i_vld),
        .out_data (i_out)
    );

    // err is only meaningful alongside resp; rdata keeps the last response.
    assign bus.dmem_resp  = d_vld;
    assign bus.dmem_err   = d_vld & d_out[XLEN];
    assign bus.dmem_rdata = d_out[XLEN-1:0];
    assign bus.imem_resp  = i_vld;
    assign bus.imem_err   = i_vld & i_out[BUS_WID];
    assign bus.imem_rdata = i_out[BUS_WID-1:0];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (LAT=1 at BASE 0, DMEM_LAT=3/IMEM_LAT=2 at
// BASE 0x10000) with an expected-response queue per port checked on every falling edge.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int XLEN = 32;
  localparam int BUS_WID = 64;
  localparam int MEM_AW = 14;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0001_0000;
  localparam int D1_LAT = 1;
  localparam int I1_LAT = 1;
  localparam int D3_LAT = 3;
  localparam int I3_LAT = 2;
  // queue entry: {due_cycle[31:0], check_data, err, data[63:0]}
  localparam int EW = 32 + 2 + 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q3[$];
  logic [63:0] hold_val [4];
  bit hold_ok [4];

  logic [31:0] model [logic [31:0]];
  logic [31:0] waddr [8];
  logic [31:0] v [4];
  logic [31:0] wv;
  logic [31:0] ra;

  mem_responder_if #(.XLEN(XLEN), .BUS_WID(BUS_WID)) bus1 ();
  mem_responder_if #(.XLEN(XLEN), .BUS_WID(BUS_WID)) bus3 ();

  mem_responder #(
    .XLEN(XLEN), .BUS_WID(BUS_WID), .MEM_AW(MEM_AW), .BASE(BASE1),
    .IMEM_LAT(I1_LAT), .DMEM_LAT(D1_LAT), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  mem_responder #(
    .XLEN(XLEN), .BUS_WID(BUS_WID), .MEM_AW(MEM_AW), .BASE(BASE3),
    .IMEM_LAT(I3_LAT), .DMEM_LAT(D3_LAT), .INIT_FILE("")
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard queue helpers (port 0: d1 dmem, 1: d1 imem, 2: d3 dmem, 3: d3 imem)
  function automatic int q_size(int p);
    int n;
    n = 0;
    case (p)
      0: n = exp_q0.size();
      1: n = exp_q1.size();
      2: n = exp_q2.size();
      3: n = exp_q3.size();
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic logic [EW-1:0] q_front(int p);
    logic [EW-1:0] e;
    e = '0;
    case (p)
      0: if (exp_q0.size() > 0) e = exp_q0[0];
      1: if (exp_q1.size() > 0) e = exp_q1[0];
      2: if (exp_q2.size() > 0) e = exp_q2[0];
      3: if (exp_q3.size() > 0) e = exp_q3[0];
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic q_push(input int p, input logic [EW-1:0] e);
    case (p)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      2: exp_q2.push_back(e);
      3: exp_q3.push_back(e);
      default: ;
    endcase
  endtask

  task automatic q_drop(input int p);
    case (p)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      2: void'(exp_q2.pop_front());
      3: void'(exp_q3.pop_front());
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // monitor: one port, called on every falling edge outside reset
  task automatic mon_port(input int p, input string tag, input logic resp, input logic err,
                          input logic [63:0] rdata);
    logic [EW-1:0] e;
    logic due_now;
    e = q_front(p);
    due_now = (q_size(p) > 0) && (e[97:66] == 32'(cyc));
    chk({tag, "_resp"}, 64'(resp), 64'(due_now));
    if (due_now) begin
      q_drop(p);
      chk({tag, "_err"}, 64'(err), 64'(e[64]));
      if (e[65]) chk({tag, "_rdata"}, rdata, e[63:0]);
      hold_ok[p] = e[65];
      hold_val[p] = e[63:0];
    end else begin
      chk({tag, "_idle_err"}, 64'(err), 64'd0);
      if (hold_ok[p]) chk({tag, "_hold"}, rdata, hold_val[p]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_port(0, "d1_dmem", bus1.dmem_resp, bus1.dmem_err, 64'(bus1.dmem_rdata));
      mon_port(1, "d1_imem", bus1.imem_resp, bus1.imem_err, bus1.imem_rdata);
      mon_port(2, "d3_dmem", bus3.dmem_resp, bus3.dmem_err, 64'(bus3.dmem_rdata));
      mon_port(3, "d3_imem", bus3.imem_resp, bus3.imem_err, bus3.imem_rdata);
    end
  end

  // driver tasks
  task automatic clr();
    bus1.imem_req = 1'b0; bus1.imem_addr = '0;
    bus1.dmem_req = 1'b0; bus1.dmem_cmd = 1'b0; bus1.dmem_width = 2'd0;
    bus1.dmem_addr = '0; bus1.dmem_wdata = '0;
    bus3.imem_req = 1'b0; bus3.imem_addr = '0;
    bus3.dmem_req = 1'b0; bus3.dmem_cmd = 1'b0; bus3.dmem_width = 2'd0;
    bus3.dmem_addr = '0; bus3.dmem_wdata = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic dm1(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input logic e_err, input logic e_chk,
                     input logic [31:0] e_data);
    bus1.dmem_req = 1'b1; bus1.dmem_cmd = cmd; bus1.dmem_width = w;
    bus1.dmem_addr = a; bus1.dmem_wdata = wd;
    q_push(0, {32'(cyc + D1_LAT), e_chk, e_err, 32'h0, e_data});
  endtask

  task automatic dm3(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input logic e_err, input logic e_chk,
                     input logic [31:0] e_data, input bit push);
    bus3.dmem_req = 1'b1; bus3.dmem_cmd = cmd; bus3.dmem_width = w;
    bus3.dmem_addr = a; bus3.dmem_wdata = wd;
    if (push) q_push(2, {32'(cyc + D3_LAT), e_chk, e_err, 32'h0, e_data});
  endtask

  task automatic im1(input logic [31:0] a, input logic e_err, input logic [63:0] e_data);
    bus1.imem_req = 1'b1; bus1.imem_addr = a;
    q_push(1, {32'(cyc + I1_LAT), 1'b1, e_err, e_data});
  endtask

  task automatic im3(input logic [31:0] a, input logic e_err, input logic [63:0] e_data);
    bus3.imem_req = 1'b1; bus3.imem_addr = a;
    q_push(3, {32'(cyc + I3_LAT), 1'b1, e_err, e_data});
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_d1_imem_resp"}, 64'(bus1.imem_resp), 64'd0);
    chk({tag, "_d1_imem_err"}, 64'(bus1.imem_err), 64'd0);
    chk({tag, "_d1_imem_rdata"}, bus1.imem_rdata, 64'd0);
    chk({tag, "_d1_dmem_resp"}, 64'(bus1.dmem_resp), 64'd0);
    chk({tag, "_d1_dmem_err"}, 64'(bus1.dmem_err), 64'd0);
    chk({tag, "_d1_dmem_rdata"}, 64'(bus1.dmem_rdata), 64'd0);
    chk({tag, "_d3_imem_resp"}, 64'(bus3.imem_resp), 64'd0);
    chk({tag, "_d3_imem_err"}, 64'(bus3.imem_err), 64'd0);
    chk({tag, "_d3_imem_rdata"}, bus3.imem_rdata, 64'd0);
    chk({tag, "_d3_dmem_resp"}, 64'(bus3.dmem_resp), 64'd0);
    chk({tag, "_d3_dmem_err"}, 64'(bus3.dmem_err), 64'd0);
    chk({tag, "_d3_dmem_rdata"}, 64'(bus3.dmem_rdata), 64'd0);
  endtask

  task automatic hold_reset();
    for (int i = 0; i < 4; i++) begin
      hold_ok[i] = 1'b1;
      hold_val[i] = 64'd0;
    end
  endtask

  initial begin
    #50000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: observed no end of stimulus, required finish within 50000 time units");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) hold_ok[i] = 1'b0;
    clr();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst_checks("reset");
    hold_reset();
    rst = 1'b0;

    // word write then read-after-write
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    // byte and half lane writes
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h100, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    step(); dm1(DMEM_CMD_WR, DMEM_W_BYTE, 32'h101, 32'h9999_99AA, 1'b0, 1'b0, 32'h0);
    step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1122_AA44);
    step(); dm1(DMEM_CMD_WR, DMEM_W_HALF, 32'h102, 32'h7777_5566, 1'b0, 1'b0, 32'h0);
    step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, 32'h100, 32'h0, 1'b0, 1'b1, 32'h5566_AA44);
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h000, 32'h0123_4567, 1'b0, 1'b0, 32'h0);
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h104, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    // errored accesses leave the array untouched
    step(); dm1(DMEM_CMD_WR, DMEM_W_HALF, 32'h103, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h102, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
    step(); dm1(DMEM_CMD_WR, DMEM_W_RSVD, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
    step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
    step(); dm1(DMEM_CMD_RD, DMEM_W_HALF, 32'h101, 32'h0, 1'b1, 1'b1, 32'h0);
    step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, 32'h100, 32'h0, 1'b0, 1'b1, 32'h5566_AA44);
    step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, 32'h000, 32'h0, 1'b0, 1'b1, 32'h0123_4567);
    step(); dm1(DMEM_CMD_RD, DMEM_W_BYTE, 32'h103, 32'h0, 1'b0, 1'b1, 32'h5566_AA44);
    step(); dm1(DMEM_CMD_RD, DMEM_W_HALF, 32'h102, 32'h0, 1'b0, 1'b1, 32'h5566_AA44);

    // same-edge fetch and write: fetch sees the old word
    step();
    dm1(DMEM_CMD_WR, DMEM_W_WORD, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    im1(32'h100, 1'b0, {32'hCAFE_F00D, 32'h5566_AA44});
    step(); im1(32'h104, 1'b0, {32'hCAFE_F00D, 32'h0000_0000});
    step(); im1(32'h0001_0000, 1'b1, 64'h0);
    step(); im1(32'hFFFF_FFF8, 1'b1, 64'h0);

    // random word traffic against a reference array
    for (int i = 0; i < 8; i++) begin
      waddr[i] = 32'h200 + 32'(4 * $urandom_range(0, 7));
      wv = $urandom;
      model[waddr[i]] = wv;
      step(); dm1(DMEM_CMD_WR, DMEM_W_WORD, waddr[i], wv, 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      ra = waddr[$urandom_range(0, 7)];
      step(); dm1(DMEM_CMD_RD, DMEM_W_WORD, ra, 32'h0, 1'b0, 1'b1, model[ra]);
    end

    // longer latency: back-to-back reads come back on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      v[i] = $urandom;
      step(); dm3(DMEM_CMD_WR, DMEM_W_WORD, BASE3 + 32'(4 * i), v[i], 1'b0, 1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step(); dm3(DMEM_CMD_RD, DMEM_W_WORD, BASE3 + 32'(4 * i), 32'h0, 1'b0, 1'b1, v[i], 1'b1);
    end
    // address below BASE wraps to a huge offset
    step(); dm3(DMEM_CMD_RD, DMEM_W_WORD, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    step(); im3(BASE3 + 32'h8, 1'b0, {v[3], v[2]});
    step(); im3(BASE3 + 32'h4, 1'b0, {v[1], v[0]});
    repeat (6) step();

    // reset with two reads in flight: neither may ever respond
    step(); dm3(DMEM_CMD_RD, DMEM_W_WORD, BASE3, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(); dm3(DMEM_CMD_RD, DMEM_W_WORD, BASE3 + 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    hold_reset();
    @(posedge clk);
    #1;
    rst_checks("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step();

    // post-reset read still sees the array contents
    step(); dm3(DMEM_CMD_RD, DMEM_W_WORD, BASE3 + 32'hC, 32'h0, 1'b0, 1'b1, v[3], 1'b1);
    repeat (6) step();

    for (int p = 0; p < 4; p++) begin
      chk($sformatf("q%0d_drained", p), 64'(q_size(p)), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
